sample_arbiter: RTL

Round-robin scheduler that shares the single host write queue among the five acquisition sample queues (DIN, ADC0, ADC1, CADC0, CADC1). It pops one sample at a time from an enabled, non-empty queue and serialises it into the write queue as a tagged byte frame, honouring write-queue backpressure. It sits between the acquisition FIFOs and the host TX FIFO and takes over the sample-forwarding duty from the command controller.

---
 rtl/sample_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sample_arbiter.sv
// Round-robin forwarder from the five acquisition sample queues into the host write queue.
// Each popped sample becomes a tagged byte frame: header, then data byte(s), stalled by full_write.
module sample_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  en,
    input  logic [7:0]  in_din,
    input  logic        em_din,
    output logic        pp_din,
    input  logic [11:0] in_adc0,
    input  logic        em_adc0,
    output logic        pp_adc0,
    input  logic [11:0] in_adc1,
    input  logic        em_adc1,
    output logic        pp_adc1,
    input  logic [11:0] in_cadc0,
    input  logic        em_cadc0,
    output logic        pp_cadc0,
    input  logic [11:0] in_cadc1,
    input  logic        em_cadc1,
    output logic        pp_cadc1,
    input  logic        full_write,
    output logic [7:0]  out_write,
    output logic        ld_write,
    output logic        busy,
    output logic [2:0]  grant,
    output logic [15:0] frame_cnt
);

    typedef enum logic [1:0] {StIdle, StHdr, StHi, StLo} state_e;

    state_e      state_q, state_d;
    logic [2:0]  last_q, last_d;
    logic [11:0] buf_q, buf_d;
    logic [2:0]  grant_q, grant_d;
    logic [4:0]  pp_q, pp_d;
    logic        ld_q, ld_d;
    logic [7:0]  out_q, out_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic [4:0]  req;
    logic        found;
    logic [2:0]  win;
    logic [2:0]  cand;
    logic [11:0] win_data;

    // Search starts one past the last winner so every source gets a turn.
    always_comb begin
        req   = en & ~{em_cadc1, em_cadc0, em_adc1, em_adc0, em_din};
        found = 1'b0;
        win   = 3'd0;
        cand  = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            cand = 3'((int'(last_q) + k) % 5);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        case (win)
            3'd0:    win_data = {4'b0000, in_din};
            3'd1:    win_data = in_adc0;
            3'd2:    win_data = in_adc1;
            3'd3:    win_data = in_cadc0;
            default: win_data = in_cadc1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        buf_d   = buf_q;
        grant_d = grant_q;
        pp_d    = 5'b00000;
        ld_d    = 1'b0;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    buf_d   = win_data;
                    grant_d = win + 3'd1;
                    pp_d    = 5'b00001 << win;
                    last_d  = win;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (!full_write) begin
                    ld_d    = 1'b1;
                    out_d   = {grant_q, 5'b00000};
                    // DIN frames carry a single data byte
                    state_d = (grant_q == 3'd1) ? StLo : StHi;
                end
            end
            StHi: begin
                if (!full_write) begin
                    ld_d    = 1'b1;
                    out_d   = {4'b0000, buf_q[11:8]};
                    state_d = StLo;
                end
            end
            StLo: begin
                if (!full_write) begin
                    ld_d    = 1'b1;
                    out_d   = buf_q[7:0];
                    cnt_d   = cnt_q + 16'd1;
                    grant_d = 3'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= 3'd4;
            buf_q   <= 12'd0;
            grant_q <= 3'd0;
            pp_q    <= 5'd0;
            ld_q    <= 1'b0;
            out_q   <= 8'd0;
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            buf_q   <= buf_d;
            grant_q <= grant_d;
            pp_q    <= pp_d;
            ld_q    <= ld_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign pp_din    = pp_q[0];
    assign pp_adc0   = pp_q[1];
    assign pp_adc1   = pp_q[2];
    assign pp_cadc0  = pp_q[3];
    assign pp_cadc1  = pp_q[4];
    assign ld_write  = ld_q;
    assign out_write = out_q;
    assign busy      = busy_q;
    assign grant     = grant_q;
    assign frame_cnt = cnt_q;

endmodule
